hex_display_scanner: RTL and testbench
======================================

// Module: hex_display_scanner
// PURPOSE
//  Time-multiplexes a 16-bit value onto a 4-digit common-anode 7-segment display.
//  Sits directly upstream of the hex-to-segment decoder: drives its 4-bit nibble input
//  and owns the active-low digit enables and the active-low decimal point.
//  Value updates are tear-free, with optional leading-zero blanking and anti-ghost blanking.
// PARAMETERS
//  TICKS_PER_DIGIT  50000  clk cycles each digit is held (>= 2)
//  BLANK_TICKS      500    leading cycles of each digit slot with all digits off (< TICKS_PER_DIGIT)
// PORTS
//  clk        in   1   system clock; single clock domain
//  rst        in   1   synchronous reset, active-high
//  value      in   16  hex value to show; [3:0] is the rightmost digit (digit 0)
//  load       in   1   1-cycle strobe: capture value and dp_mask
//  dp_mask    in   4   1 = decimal point lit on that digit; captured with value
//  blank_lz   in   1   1 = suppress leading zero digits (level, sampled live)
//  digit_nib  out  4   nibble for the current digit; feeds decoder SS input
//  digit_en_n out  4   active-low digit enables; at most one bit is 0
//  dp_n       out  1   active-low decimal point for the enabled digit
//  frame      out  1   1-cycle pulse when digit index wraps 3 -> 0
// BEHAVIOUR
//  Reset: tick=0, idx=0, disp=0, disp_dp=0, pend_v=0, digit_nib=0, digit_en_n=4'b1111,
//   dp_n=1, frame=0. rst mid-frame aborts scan and discards any pending load.
//  Prescaler: tick counts 0..TICKS_PER_DIGIT-1 and wraps; end-of-slot = (tick==TICKS_PER_DIGIT-1).
//   At end-of-slot idx advances 0->1->2->3->0. frame asserts in the cycle after
//   the end-of-slot where idx goes 3->0.
//  Load path: load=1 captures {value,dp_mask} into pend and sets pend_v=1. A later
//   load before the frame boundary overwrites pend (last load wins).
//  Frame boundary: end-of-slot with idx==3. If pend_v, then disp<=pend, disp_dp<=pend_dp
//   and pend_v<=0. If load=1 in that same cycle, the new value/dp_mask go directly to disp,
//   bypassing pend, and pend_v<=0. Digits never show a mix of old and new values.
//  Outputs: all outputs are registered, one cycle after tick/idx.
//   digit_nib = disp[4*idx+:4], dp_n = ~disp_dp[idx].
//   digit_en_n = 4'b1111 when tick < BLANK_TICKS or the digit is suppressed;
//   otherwise it is ~(1<<idx).
//  Leading-zero suppression (blank_lz=1): digit k (k=3..1) is suppressed when disp
//   nibbles k..3 are all zero and disp_dp[k]==0. Digit 0 is never suppressed.
//   disp=16'h0000 therefore shows "   0".
//  Width rules: tick is $clog2(TICKS_PER_DIGIT) bits. idx is 2 bits with natural wrap.
//   No arithmetic is applied to value.
// STRUCTURE
//  Shared package disp_pkg: NUM_DIGITS=4, DIGITS_OFF=4'b1111, typedef logic [3:0] nib_t.
//  One sub-module: scan_tick_gen (prescaler; params TICKS_PER_DIGIT, BLANK_TICKS;
//   outputs slot_end and in_blank). Index, load/pending and output registers stay in the top.
// TESTING  (TICKS_PER_DIGIT=4, BLANK_TICKS=1)
//  Reset -> digit_en_n=4'b1111, dp_n=1, digit_nib=0, frame=0. Hold rst during a
//   pending load -> pend discarded, and the display stays 0 after release.
//  load value=16'h1A2F -> from the next frame, digit_nib cycles F,2,A,1.
//   digit_en_n cycles 1110,1101,1011,0111, each held 3 cycles after 1 cycle of 1111.
//  load 16'h1234 mid-frame, then load 16'h5678 before wrap -> the current frame
//   finishes with the old value and the next frame shows only 8,7,6,5.
//  load asserted exactly at end-of-slot with idx=3 -> the new value appears on digit 0
//   in the immediately following slot.
//  blank_lz=1, value=16'h00A0 -> digits 3 and 2 stay 1111 during their slots;
//   digits 1 and 0 show A and 0. With dp_mask=4'b0100, digit 2 lights with nib 0 and dp_n=0.
//  Free-run 3 frames -> frame pulses exactly once every 16 cycles, and no cycle ever
//   has two digit_en_n bits low.

Source files
------------

// File: rtl/disp_pkg.sv
// Shared definitions for the 4-digit multiplexed 7-segment display scanner.
//
// Contents:
//   NUM_DIGITS    number of digits on the display (4)
//   DIGITS_OFF    active-low digit enable pattern with every digit dark
//   nib_t         one hex digit
//   digit_select  active-low one-cold enable for a digit index
//   lz_suppress   leading-zero suppression mask for a displayed value
package disp_pkg;

  localparam int         NUM_DIGITS = 4;
  localparam logic [3:0] DIGITS_OFF = 4'b1111;

  typedef logic [3:0] nib_t;

  // Active-low enable for digit idx: exactly one bit low.
  function automatic logic [3:0] digit_select(input logic [1:0] idx);
    digit_select = ~(4'b0001 << idx);
  endfunction

  // Bit k set means digit k is a leading zero that should stay dark.
  // A lit decimal point keeps its digit visible even when the nibble is zero.
  // Digit 0 always shows, so a zero value reads "   0".
  function automatic logic [3:0] lz_suppress(input logic [15:0] v,
                                             input logic [3:0]  dp);
    logic [3:0] s;
    s    = 4'b0000;
    s[3] = (v[15:12] == 4'h0) && !dp[3];
    s[2] = (v[15:8]  == 8'h00) && !dp[2];
    s[1] = (v[15:4]  == 12'h000) && !dp[1];
    lz_suppress = s;
  endfunction

endpackage

// File: rtl/scan_tick_gen.sv
// Digit-slot prescaler for the display scanner.
//
// A counter runs 0..TICKS_PER_DIGIT-1 and wraps; each full count is one
// digit slot.
//
// Ports:
//   clk       system clock
//   rst       synchronous reset, active-high (counter back to 0)
//   slot_end  high in the last cycle of a digit slot
//   in_blank  high during the first BLANK_TICKS cycles of a slot, when every
//             digit is held dark so the previous digit does not ghost
module scan_tick_gen #(
  parameter int TICKS_PER_DIGIT = 50000,
  parameter int BLANK_TICKS     = 500
) (
  input  logic clk,
  input  logic rst,
  output logic slot_end,
  output logic in_blank
);

  localparam int TW = (TICKS_PER_DIGIT > 1) ? $clog2(TICKS_PER_DIGIT) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICKS_PER_DIGIT - 1);
  localparam logic [TW-1:0] BLANK_LIM = TW'(BLANK_TICKS);

  logic [TW-1:0] tick;

  always_ff @(posedge clk) begin
    if (rst) begin
      tick <= '0;
    end else if (tick == TICK_LAST) begin
      tick <= '0;
    end else begin
      tick <= tick + 1'b1;
    end
  end

  assign slot_end = (tick == TICK_LAST);
  assign in_blank = (tick < BLANK_LIM);

endmodule

// File: rtl/hex_display_scanner.sv
// Time-multiplexes a 16-bit hex value onto a 4-digit common-anode display.
//
// Ports:
//   clk         system clock
//   rst         synchronous reset, active-high
//   value       value to show; value[3:0] is the rightmost digit (digit 0)
//   load        1-cycle strobe capturing value and dp_mask
//   dp_mask     decimal point per digit (1 = lit), captured with value
//   blank_lz    1 = leading zero digits stay dark (live level)
//   digit_nib   nibble of the digit being scanned, to the segment decoder
//   digit_en_n  active-low digit enables, at most one low
//   dp_n        active-low decimal point for the scanned digit
//   frame       1-cycle pulse after the scan wraps from digit 3 to digit 0
//
// Handshake: load is a plain strobe with no back-pressure. Every cycle with
// load=1 is taken; a load mid-frame waits in a pending register (last one
// wins) and is moved to the display only at the frame boundary, so a frame
// never mixes old and new digits. A load in the boundary cycle itself goes
// straight to the display.
module hex_display_scanner
  import disp_pkg::*;
#(
  parameter int TICKS_PER_DIGIT = 50000,
  parameter int BLANK_TICKS     = 500
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] value,
  input  logic        load,
  input  logic [3:0]  dp_mask,
  input  logic        blank_lz,
  output logic [3:0]  digit_nib,
  output logic [3:0]  digit_en_n,
  output logic        dp_n,
  output logic        frame
);

  logic        slot_end;
  logic        in_blank;
  logic [1:0]  idx;
  logic        frame_end;

  logic [15:0] disp;
  logic [3:0]  disp_dp;
  logic [15:0] pend;
  logic [3:0]  pend_dp;
  logic        pend_v;

  logic [3:0]  sup;

  scan_tick_gen #(
    .TICKS_PER_DIGIT (TICKS_PER_DIGIT),
    .BLANK_TICKS     (BLANK_TICKS)
  ) u_tick (
    .clk      (clk),
    .rst      (rst),
    .slot_end (slot_end),
    .in_blank (in_blank)
  );

  assign frame_end = slot_end && (idx == 2'd3);

  // Digit index; the 2-bit counter wraps 3 -> 0 on its own.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx <= 2'd0;
    end else if (slot_end) begin
      idx <= idx + 2'd1;
    end
  end

  // Load path: pending register plus tear-free swap at the frame boundary.
  always_ff @(posedge clk) begin
    if (rst) begin
      disp    <= 16'h0000;
      disp_dp <= 4'b0000;
      pend    <= 16'h0000;
      pend_dp <= 4'b0000;
      pend_v  <= 1'b0;
    end else if (frame_end) begin
      if (load) begin
        // Fresh value beats anything waiting in pend.
        disp    <= value;
        disp_dp <= dp_mask;
      end else if (pend_v) begin
        disp    <= pend;
        disp_dp <= pend_dp;
      end
      pend_v <= 1'b0;
    end else if (load) begin
      pend    <= value;
      pend_dp <= dp_mask;
      pend_v  <= 1'b1;
    end
  end

  always_comb begin
    sup = 4'b0000;
    if (blank_lz) begin
      sup = lz_suppress(disp, disp_dp);
    end
  end

  // Registered outputs: they follow tick/idx by one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      digit_nib  <= 4'h0;
      digit_en_n <= DIGITS_OFF;
      dp_n       <= 1'b1;
      frame      <= 1'b0;
    end else begin
      digit_nib  <= disp[{idx, 2'b00} +: 4];
      dp_n       <= ~disp_dp[idx];
      digit_en_n <= (in_blank || sup[idx]) ? DIGITS_OFF : digit_select(idx);
      frame      <= frame_end;
    end
  end

endmodule

// File: tb/tb_hex_display_scanner.sv
// Directed bench for hex_display_scanner with 4-cycle digit slots and a
// 1-cycle blanking lead-in, so a full frame is 16 cycles.
module tb_hex_display_scanner;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] value;
  logic        load;
  logic [3:0]  dp_mask;
  logic        blank_lz;
  logic [3:0]  digit_nib;
  logic [3:0]  digit_en_n;
  logic        dp_n;
  logic        frame;

  int checks   = 0;
  int failures = 0;

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  hex_display_scanner #(
    .TICKS_PER_DIGIT (4),
    .BLANK_TICKS     (1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .value      (value),
    .load       (load),
    .dp_mask    (dp_mask),
    .blank_lz   (blank_lz),
    .digit_nib  (digit_nib),
    .digit_en_n (digit_en_n),
    .dp_n       (dp_n),
    .frame      (frame)
  );

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [15:0] got,
                       input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One clock: inputs settle before the rising edge, outputs are
  // sampled on the following falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Walks one 16-cycle frame starting at a frame boundary and checks every
  // cycle against the expected value v, decimal points dp and the
  // hand-derived suppression mask sup. Up to two loads (lj < 0 = none) are
  // driven at chosen cycles of the frame; j == 15 is the boundary cycle.
  task automatic check_frame(input string tag,
                             input logic [15:0] v, input logic [3:0] dp,
                             input logic [3:0] sup,
                             input int lj1, input logic [15:0] lv1,
                             input logic [3:0] ld1,
                             input int lj2, input logic [15:0] lv2,
                             input logic [3:0] ld2);
    for (int j = 0; j < 16; j++) begin
      int         i;
      int         t;
      logic [3:0] exp_en;
      logic [3:0] exp_nib;
      i = j / 4;
      t = j % 4;
      if (j == lj1) begin
        value = lv1; dp_mask = ld1; load = 1'b1;
      end else if (j == lj2) begin
        value = lv2; dp_mask = ld2; load = 1'b1;
      end
      step();
      load = 1'b0;
      exp_nib = v[4*i +: 4];
      exp_en  = 4'b1111;
      if (t != 0 && !sup[i]) exp_en[i] = 1'b0;
      check($sformatf("%s_nib_j%0d", tag, j), 16'(digit_nib), 16'(exp_nib));
      check($sformatf("%s_en_j%0d", tag, j), 16'(digit_en_n), 16'(exp_en));
      check($sformatf("%s_dp_j%0d", tag, j), 16'(dp_n), 16'(!dp[i]));
      check($sformatf("%s_frame_j%0d", tag, j), 16'(frame), 16'(j == 15));
      check($sformatf("%s_onecold_j%0d", tag, j),
            16'($countones(~digit_en_n) <= 1), 16'd1);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_nib"},   16'(digit_nib),  16'h0);
    check({tag, "_en"},    16'(digit_en_n), 16'hF);
    check({tag, "_dp"},    16'(dp_n),       16'h1);
    check({tag, "_frame"}, 16'(frame),      16'h0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1; value = 16'h0; load = 1'b0; dp_mask = 4'h0; blank_lz = 1'b0;
    @(negedge clk);
    step(); step(); step();
    check_reset_outputs("reset");

    // Start scanning, queue a load, then reset mid-frame: it must be lost.
    rst = 1'b0;
    step(); step();
    value = 16'h1234; dp_mask = 4'hF; load = 1'b1;
    step();
    load = 1'b0;
    step(); step();
    rst = 1'b1;
    step(); step();
    check_reset_outputs("midrst");
    rst = 1'b0;

    // Two frames: the second is past a boundary, so a surviving pend would show.
    check_frame("zero0", 16'h0000, 4'h0, 4'h0, -1, 16'h0, 4'h0, -1, 16'h0, 4'h0);
    check_frame("zero1", 16'h0000, 4'h0, 4'h0, -1, 16'h0, 4'h0, -1, 16'h0, 4'h0);

    // Mid-frame load shows from the next frame.
    check_frame("old0", 16'h0000, 4'h0, 4'h0, 5, 16'h1A2F, 4'h0, -1, 16'h0, 4'h0);
    // Two loads in this frame: last one wins, current frame untouched.
    check_frame("v1a2f", 16'h1A2F, 4'h0, 4'h0, 2, 16'h1234, 4'h0, 10, 16'h5678, 4'h0);
    // Load on the boundary cycle bypasses pend.
    check_frame("v5678", 16'h5678, 4'h0, 4'h0, 15, 16'hBEEF, 4'b1001, -1, 16'h0, 4'h0);
    check_frame("vbeef", 16'hBEEF, 4'b1001, 4'h0, 15, 16'h00A0, 4'h0, -1, 16'h0, 4'h0);

    // Leading-zero blanking.
    blank_lz = 1'b1;
    check_frame("lz_a0", 16'h00A0, 4'h0, 4'b1100, 15, 16'h00A0, 4'b0100, -1, 16'h0, 4'h0);
    check_frame("lz_a0dp", 16'h00A0, 4'b0100, 4'b1000, 15, 16'h0000, 4'h0, -1, 16'h0, 4'h0);
    check_frame("lz_zero", 16'h0000, 4'h0, 4'b1110, -1, 16'h0, 4'h0, -1, 16'h0, 4'h0);

    // Free run with blanking off.
    blank_lz = 1'b0;
    check_frame("run0", 16'h0000, 4'h0, 4'h0, -1, 16'h0, 4'h0, -1, 16'h0, 4'h0);
    check_frame("run1", 16'h0000, 4'h0, 4'h0, -1, 16'h0, 4'h0, -1, 16'h0, 4'h0);
    check_frame("run2", 16'h0000, 4'h0, 4'h0, -1, 16'h0, 4'h0, -1, 16'h0, 4'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
